apb_xfer_ctrl: RTL and testbench
================================

# apb_xfer_ctrl

Sequencer for the pipelined core's APB master port. Sits between the LSU's peripheral window in the M stage and the APB bus. Converts a single-cycle LSU request into a compliant SETUP/ACCESS transfer with wait-state handling, address-decode error and timeout abort. Holds the pipeline through a stall request to the hazard unit until the response is delivered.

## Interface
- TIMEOUT, 255: PREADY-low ACCESS cycles tolerated before abort (1..255)
- PBASE, 2'b10: value of req_addr[15:14] that selects the APB window
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_vld  in  1  LSU request for the peripheral window (M stage)
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  16  byte address
- req_wdata  in  32  write data
- req_strb  in  4  byte strobes
- rsp_vld  out  1  one-cycle completion pulse
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  slave error, decode error or timeout; valid with rsp_vld
- stall_req  out  1  to hazard unit; freezes F/D/E/M while high
- PSEL  out  4  one-hot slave select, index = req_addr[13:12]
- PENABLE, PWRITE  out  1 each  APB controls
- PADDR  out  16, PWDATA  out  32, PSTRB  out  4  APB address, write data, strobes
- PREADY, PSLVERR  in  1 each; PRDATA  in  32  muxed slave response

## Operation
- FSM states IDLE, SETUP, ACCESS, RESP; reset state IDLE.
- IDLE, req_vld=1, req_addr[15:14]==PBASE: latch wr/addr/wdata/strb, go SETUP.
- IDLE, req_vld=1, decode miss: go RESP with err=1, rdata=0; no APB activity.
- SETUP: PSEL[addr[13:12]]=1, PENABLE=0; always go ACCESS next cycle.
- ACCESS: PSEL and PENABLE=1. On PREADY=1: capture PRDATA (reads only) and PSLVERR, go RESP.
- Timeout: counter cleared on SETUP entry, increments each ACCESS cycle with PREADY=0. When the count reaches TIMEOUT with PREADY still 0: go RESP with err=1, rdata=0. PSEL and PENABLE drop on the next edge.
- RESP: rsp_vld=1 for exactly one cycle; go IDLE. req_vld is ignored in RESP because it is the same stalled instruction.
- stall_req = (IDLE & req_vld) | SETUP | ACCESS. It is combinational from req_vld in IDLE and is low in RESP, so the instruction leaves M with the response.
- PADDR, PWRITE, PWDATA and PSTRB are registered. They are stable from SETUP through the last ACCESS cycle and hold their last values in IDLE/RESP.
- PSLVERR and PRDATA are sampled only when PENABLE & PREADY.
- Writes return rsp_rdata=0. Slave error on a read still returns the captured PRDATA.

## Timing
- Reset (async, immediate, including mid-transfer): state IDLE, all outputs 0, counter 0. PSEL and PENABLE deassert without completing the transfer.
- Zero-wait transfer: c0 IDLE+req_vld (stall=1); c1 SETUP; c2 ACCESS with PREADY=1; c3 RESP (rsp_vld=1, stall=0). Latency is 3 cycles from req_vld to rsp_vld; stall is high for 3 cycles.
- Each PREADY-low ACCESS cycle adds one cycle.
- Timeout: rsp_vld arrives TIMEOUT+3 cycles after req_vld.
- Decode miss: c0 IDLE+req_vld (stall=1); c1 RESP with err.
- Back-to-back: a new req_vld in the cycle after RESP (IDLE) starts SETUP with no bubble. Peak throughput is one transfer per 4 cycles.
- All outputs except stall_req are registered.

## Test plan
- Reset: hold rst_n=0 with req_vld=1 → PSEL=0, PENABLE=0, rsp_vld=0, stall_req=0. Release → IDLE.
- Zero-wait read of 0x9004, PREADY=1, PRDATA=0xDEADBEEF → PSEL=4'b0010 at c1–c2, PENABLE=1 at c2 only. At c3: rsp_vld=1, rsp_rdata=0xDEADBEEF, err=0. stall_req high at c0–c2.
- Write to 0xB008, wdata=0x12345678, strb=4'b0011, PREADY low for 2 ACCESS cycles → PADDR, PWDATA, PSTRB and PWRITE stable across SETUP plus 3 ACCESS cycles. rsp_vld 5 cycles after req_vld with rsp_rdata=0.
- PSLVERR=1 with PREADY=1 on a read of 0x8000 → rsp_err=1, PRDATA captured. A second request starts SETUP the cycle after RESP.
- Timeout with TIMEOUT=4 and PREADY tied low → rsp_err=1, rsp_vld 7 cycles after req_vld. PSEL=0 in the RESP cycle.
- Decode miss on req_addr=0x1000 → no PSEL activity, rsp_vld=1 with rsp_err=1 one cycle after req_vld. Also: rst_n asserted mid-ACCESS → PSEL and PENABLE drop immediately, no rsp_vld.

Source files
------------

// File: rtl/apb_xfer_ctrl_if.sv
// LSU-side request/response and APB bus signals of the transfer sequencer.
interface apb_xfer_ctrl_if;
  logic        req_vld;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_vld;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall_req;
  logic [3:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] PRDATA;

  modport master (
    input  req_vld, req_wr, req_addr,
    input  req_wdata, req_strb,
    input  PREADY, PSLVERR, PRDATA,
    output rsp_vld, rsp_rdata, rsp_err,
    output stall_req,
    output PSEL, PENABLE, PWRITE,
    output PADDR, PWDATA, PSTRB
  );

  modport slave (
    output req_vld, req_wr, req_addr,
    output req_wdata, req_strb,
    output PREADY, PSLVERR, PRDATA,
    input  rsp_vld, rsp_rdata, rsp_err,
    input  stall_req,
    input  PSEL, PENABLE, PWRITE,
    input  PADDR, PWDATA, PSTRB
  );
endinterface

// File: rtl/apb_xfer_ctrl.sv
// APB master sequencer: LSU request -> SETUP/ACCESS transfer,
// with wait states, decode-miss and timeout abort, pipeline stall.
module apb_xfer_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [1:0]  PBASE   = 2'b10
) (
  input  logic            clk,
  input  logic            rst_n,
  apb_xfer_ctrl_if.master bus
);
  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, RESP
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  psel_q, psel_d;
  logic        pen_q, pen_d;
  logic        pwr_q, pwr_d;
  logic [15:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [3:0]  pstrb_q, pstrb_d;
  logic        rvld_q, rvld_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rerr_q, rerr_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pwr_d    = pwr_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rvld_d   = 1'b0;
    rdata_d  = '0;
    rerr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_vld) begin
          if (bus.req_addr[15:14] == PBASE) begin
            state_d  = SETUP;
            cnt_d    = '0;
            pwr_d    = bus.req_wr;
            paddr_d  = bus.req_addr;
            pwdata_d = bus.req_wdata;
            pstrb_d  = bus.req_strb;
          end else begin
            state_d = RESP;
            rvld_d  = 1'b1;
            rerr_d  = 1'b1;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.PREADY) begin
          state_d = RESP;
          rvld_d  = 1'b1;
          rerr_d  = bus.PSLVERR;
          rdata_d = pwr_q ? '0 : bus.PRDATA;
        end else if (cnt_q == TMO) begin
          state_d = RESP;
          rvld_d  = 1'b1;
          rerr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus controls follow the next state so they are registered outputs.
  always_comb begin
    psel_d = '0;
    pen_d  = 1'b0;
    if (state_d == SETUP || state_d == ACCESS)
      psel_d = 4'b0001 << paddr_d[13:12];
    if (state_d == ACCESS)
      pen_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      psel_q   <= '0;
      pen_q    <= 1'b0;
      pwr_q    <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rvld_q   <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwr_q    <= pwr_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rvld_q   <= rvld_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  // Gated by rst_n so a held request cannot stall a core in reset.
  assign bus.stall_req = rst_n &
    ((state_q == IDLE & bus.req_vld) |
     state_q == SETUP | state_q == ACCESS);

  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = pen_q;
  assign bus.PWRITE    = pwr_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.rsp_vld   = rvld_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = rerr_q;
endmodule

// File: tb/tb_apb_xfer_ctrl.sv
// Bench for apb_xfer_ctrl: vector table, directed corners,
// randomized transfers against a transaction-level model.
module tb_apb_xfer_ctrl;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  apb_xfer_ctrl_if bus ();

  apb_xfer_ctrl #(.TIMEOUT(TMO), .PBASE(2'b10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [3:0]  st;
    int          waits;
    logic        se;
    logic [31:0] rd;
    logic        e_err;
    logic [31:0] e_rdata;
    int          e_lat;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level expectation from the transfer rules.
  task automatic model(input logic wr,
                       input logic [15:0] addr,
                       input int waits,
                       input logic se,
                       input logic [31:0] rd,
                       output logic err,
                       output logic [31:0] rdata,
                       output int lat);
    if (addr[15:14] != 2'b10) begin
      err = 1'b1; rdata = '0; lat = 1;
    end else if (waits > TMO) begin
      err = 1'b1; rdata = '0; lat = TMO + 3;
    end else begin
      err = se; rdata = wr ? 32'h0 : rd;
      lat = 3 + waits;
    end
  endtask

  // Entered and left just after a rising edge with the DUT idle.
  task automatic xfer(input logic wr,
                      input logic [15:0] addr,
                      input logic [31:0] wd,
                      input logic [3:0] st,
                      input int waits,
                      input logic se,
                      input logic [31:0] rd,
                      output int lat,
                      output logic [31:0] rdat,
                      output logic err,
                      output logic ok);
    int nacc;
    logic [3:0] epsel;
    epsel = 4'b0001 << addr[13:12];
    lat = -1; rdat = 'x; err = 1'bx;
    ok = 1'b1; nacc = 0;
    bus.req_vld = 1'b1; bus.req_wr = wr;
    bus.req_addr = addr; bus.req_wdata = wd;
    bus.req_strb = st; bus.PREADY = 1'b0;
    #1;
    if (bus.stall_req !== 1'b1) ok = 1'b0;
    @(posedge clk); #1;
    bus.req_vld = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.rsp_vld === 1'b1) begin
        lat = c; rdat = bus.rsp_rdata;
        err = bus.rsp_err;
        if (bus.stall_req !== 1'b0) ok = 1'b0;
        if (bus.PSEL !== 4'b0) ok = 1'b0;
        if (bus.PENABLE !== 1'b0) ok = 1'b0;
        // A request seen in RESP must be ignored.
        bus.req_vld = 1'b1;
        bus.req_addr = 16'h8FF0;
        break;
      end
      if (bus.PSEL !== epsel) ok = 1'b0;
      if (bus.PADDR !== addr) ok = 1'b0;
      if (bus.PWRITE !== wr) ok = 1'b0;
      if (wr && bus.PWDATA !== wd) ok = 1'b0;
      if (bus.PSTRB !== st) ok = 1'b0;
      if (bus.stall_req !== 1'b1) ok = 1'b0;
      if (bus.PENABLE === 1'b1) begin
        if (nacc == waits) begin
          bus.PREADY = 1'b1;
          bus.PSLVERR = se;
          bus.PRDATA = rd;
        end else begin
          bus.PREADY = 1'b0;
          bus.PSLVERR = 1'b1;
          bus.PRDATA = ~rd;
        end
        nacc++;
      end else begin
        bus.PREADY = 1'b1;
        bus.PSLVERR = 1'b1;
        bus.PRDATA = ~rd;
      end
      @(posedge clk); #1;
    end
    bus.PREADY = 1'b0;
    bus.PSLVERR = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run(input string nm,
                     input logic wr,
                     input logic [15:0] addr,
                     input logic [31:0] wd,
                     input logic [3:0] st,
                     input int waits,
                     input logic se,
                     input logic [31:0] rd,
                     input logic e_err,
                     input logic [31:0] e_rd,
                     input int e_lat);
    int lat;
    logic [31:0] rdat;
    logic err, ok;
    xfer(wr, addr, wd, st, waits, se, rd,
         lat, rdat, err, ok);
    chk({nm, "_lat"}, 32'(lat), 32'(e_lat));
    chk({nm, "_rdata"}, rdat, e_rd);
    chk({nm, "_err"}, {31'b0, err}, {31'b0, e_err});
    chk({nm, "_apb"}, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    logic e_err;
    logic [31:0] e_rd;
    int e_lat;

    vt[0] = '{1'b0, 16'h9004, 32'h0, 4'hF, 0, 1'b0,
              32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 3};
    vt[1] = '{1'b1, 16'hB008, 32'h12345678, 4'b0011, 2,
              1'b0, 32'h0BADF00D, 1'b0, 32'h0, 5};
    vt[2] = '{1'b0, 16'h8000, 32'h0, 4'hF, 0, 1'b1,
              32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 3};
    vt[3] = '{1'b0, 16'hA010, 32'h0, 4'hF, 0, 1'b0,
              32'h00001234, 1'b0, 32'h00001234, 3};
    vt[4] = '{1'b0, 16'h9FFC, 32'h0, 4'hF, 100, 1'b0,
              32'h11111111, 1'b1, 32'h0, 7};
    vt[5] = '{1'b0, 16'h1000, 32'h0, 4'hF, 0, 1'b0,
              32'h22222222, 1'b1, 32'h0, 1};
    vt[6] = '{1'b1, 16'h8100, 32'hA5A5A5A5, 4'b1000, 4,
              1'b0, 32'h33333333, 1'b0, 32'h0, 7};
    vt[7] = '{1'b0, 16'hC000, 32'h0, 4'hF, 0, 1'b0,
              32'h44444444, 1'b1, 32'h0, 1};
    vt[8] = '{1'b0, 16'h8004, 32'h0, 4'hF, 4, 1'b0,
              32'h55AA55AA, 1'b0, 32'h55AA55AA, 7};
    vt[9] = '{1'b1, 16'hB000, 32'hFFFF0000, 4'b0101, 1,
              1'b1, 32'h66666666, 1'b1, 32'h0, 4};

    bus.req_vld = 1'b1; bus.req_wr = 1'b0;
    bus.req_addr = 16'h9004; bus.req_wdata = '0;
    bus.req_strb = '0; bus.PREADY = 1'b0;
    bus.PSLVERR = 1'b0; bus.PRDATA = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_psel", {28'b0, bus.PSEL}, 32'h0);
    chk("rst_penable", {31'b0, bus.PENABLE}, 32'h0);
    chk("rst_rsp_vld", {31'b0, bus.rsp_vld}, 32'h0);
    chk("rst_stall", {31'b0, bus.stall_req}, 32'h0);
    bus.req_vld = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_psel", {28'b0, bus.PSEL}, 32'h0);

    foreach (vt[i])
      run($sformatf("vec%0d", i), vt[i].wr, vt[i].addr,
          vt[i].wd, vt[i].st, vt[i].waits, vt[i].se,
          vt[i].rd, vt[i].e_err, vt[i].e_rdata,
          vt[i].e_lat);

    bus.req_vld = 1'b1; bus.req_wr = 1'b0;
    bus.req_addr = 16'h9004; bus.PREADY = 1'b0;
    @(posedge clk); #1;
    bus.req_vld = 1'b0;
    @(posedge clk); #1;
    chk("midrst_pen_before", {31'b0, bus.PENABLE}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_psel", {28'b0, bus.PSEL}, 32'h0);
    chk("midrst_penable", {31'b0, bus.PENABLE}, 32'h0);
    chk("midrst_paddr", {16'b0, bus.PADDR}, 32'h0);
    @(posedge clk); #3 rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.rsp_vld === 1'b1) seen = 1'b1;
    end
    chk("midrst_no_rsp", {31'b0, seen}, 32'h0);

    for (int i = 0; i < 40; i++) begin
      logic wr, se;
      logic [15:0] addr;
      logic [31:0] wd, rd;
      logic [3:0] st;
      int waits;
      wr = 1'($urandom);
      addr = 16'($urandom);
      if ($urandom_range(0, 3) != 0) addr[15:14] = 2'b10;
      wd = $urandom; rd = $urandom;
      st = 4'($urandom);
      waits = $urandom_range(0, 6);
      se = ($urandom_range(0, 3) == 0);
      model(wr, addr, waits, se, rd, e_err, e_rd, e_lat);
      run($sformatf("rnd%0d", i), wr, addr, wd, st,
          waits, se, rd, e_err, e_rd, e_lat);
    end
    bus.req_vld = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
